// File: rtl/ds_sched_pkg.sv
// Shared types and default configuration for the MAC scheduler.
package ds_sched_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          DEF_NREQ             = 4;
  localparam int          DEF_TW               = 6;
  localparam int unsigned DEF_TAPS [DEF_NREQ]  = '{13, 19, 27, 32};

endpackage

// File: rtl/ds_rr_arb.sv
// Round-robin arbiter: combinational pick starting at the pointer, plus the
// registered pointer that advances past the winner only when a grant is taken.
module ds_rr_arb
  import ds_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] pend,
  input  logic            upd,
  output logic [NREQ-1:0] win_oh,
  output logic [IW-1:0]   win_idx,
  output logic            win_any
);

  logic [IW-1:0] ptr_q;

  // Scan from the pointer upward (wrapping) and take the first pending index.
  always_comb begin
    int idx;
    idx     = 0;
    win_oh  = '0;
    win_idx = '0;
    win_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!win_any && pend[idx]) begin
        win_any     = 1'b1;
        win_oh[idx] = 1'b1;
        win_idx     = IW'(idx);
      end
    end
  end

  // Pointer moves to the index after the winner on each grant; reset favours 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (upd) begin
      ptr_q <= (int'(win_idx) == NREQ - 1) ? '0 : win_idx + IW'(1);
    end
  end

endmodule

// File: rtl/ds_mac_sched.sv
// Time-shares one MAC engine between NREQ FIR stages. Each stage pulses req
// when a new sample is ready; the scheduler grants round-robin, walks tap_idx
// over that stage's taps and pulses done when the accumulator holds the result.
// Optional feature: define DS_MAC_SCHED_OVERRUN_EN to record sticky per-stage
// overrun flags for requests that arrive while already pending.
// Handshake: req is a one-cycle pulse with no back-pressure; it is latched into
// a pending bit and served once; duplicates before service merge into one.
module ds_mac_sched
  import ds_sched_pkg::*;
#(
  parameter int          NREQ         = DEF_NREQ,
  parameter int          TW           = DEF_TW,
  parameter int unsigned TAPS [NREQ]  = DEF_TAPS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic            mac_en,
  output logic            mac_clr,
  output logic [TW-1:0]   tap_idx,
  output logic            mac_last,
  output logic [NREQ-1:0] done,
  output logic            busy,
  output logic [NREQ-1:0] overrun,
  output logic [1:0]      state_dbg
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q;
  logic [TW-1:0]   tap_q;
  logic [TW-1:0]   last_tap;
  logic [NREQ-1:0] pend_q;
  logic [NREQ-1:0] pend_clr;
  logic [NREQ-1:0] owner_oh;
  logic [NREQ-1:0] win_oh;
  logic [IW-1:0]   win_idx;
  logic            win_any;
  logic            arb_fire;

  assign arb_fire  = (state_q == IDLE) && win_any;
  assign owner_oh  = NREQ'(1) << owner_q;
  assign tap_idx   = tap_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

  ds_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .pend    (pend_q),
    .upd     (arb_fire),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_any (win_any)
  );

  // Final tap index of the current owner.
  always_comb begin
    last_tap = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(owner_q) == i) last_tap = TW'(TAPS[i] - 1);
    end
  end

  // Next state and MAC control; grant is the live winner while arbitrating.
  always_comb begin
    state_d  = state_q;
    grant    = '0;
    mac_en   = 1'b0;
    mac_clr  = 1'b0;
    mac_last = 1'b0;
    done     = '0;
    pend_clr = '0;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          grant    = win_oh;
          pend_clr = win_oh;
          state_d  = RUN;
        end
      end
      RUN: begin
        grant   = owner_oh;
        mac_en  = 1'b1;
        mac_clr = (tap_q == '0);
        if (tap_q == last_tap) begin
          mac_last = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        grant   = owner_oh;
        done    = owner_oh;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, owner, tap counter and pending bits; a new req beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      tap_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= (pend_q & ~pend_clr) | req;
      if (arb_fire) begin
        owner_q <= win_idx;
        tap_q   <= '0;
      end else if (state_q == RUN && !mac_last) begin
        tap_q <= tap_q + TW'(1);
      end
    end
  end

`ifdef DS_MAC_SCHED_OVERRUN_EN
  logic [NREQ-1:0] ovr_q;

  // Sticky flag: a req landing on a pending bit that is not being granted now.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovr_q <= '0;
    end else begin
      ovr_q <= ovr_q | (req & pend_q & ~pend_clr);
    end
  end

  assign overrun = ovr_q;
`else
  assign overrun = '0;
`endif

endmodule

// File: tb/tb_ds_mac_sched.sv
// Directed bench for ds_mac_sched with default parameters (taps 13,19,27,32).
module tb_ds_mac_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic       mac_en;
  logic       mac_clr;
  logic [5:0] tap_idx;
  logic       mac_last;
  logic [3:0] done;
  logic       busy;
  logic [3:0] overrun;
  logic [1:0] state_dbg;

  int passed = 0;
  int total  = 0;

`ifdef DS_MAC_SCHED_OVERRUN_EN
  localparam logic [3:0] OVR_EXP = 4'b0100;
`else
  localparam logic [3:0] OVR_EXP = 4'b0000;
`endif

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  ds_mac_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .grant     (grant),
    .mac_en    (mac_en),
    .mac_clr   (mac_clr),
    .tap_idx   (tap_idx),
    .mac_last  (mac_last),
    .done      (done),
    .busy      (busy),
    .overrun   (overrun),
    .state_dbg (state_dbg)
  );

  // driver tasks (inputs change on the falling edge)
  task automatic apply_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse(input logic [3:0] mask);
    req = mask;
    @(negedge clk);
    req = '0;
  endtask

  // Advance until a done pulse or the limit; seen is 0 on timeout.
  task automatic wait_done(input int limit, output int cycles, output logic [3:0] seen);
    cycles = 0;
    seen   = '0;
    while (cycles < limit) begin
      @(negedge clk);
      cycles++;
      if (done !== 4'b0000) begin
        seen = done;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (grant !== 4'b0000) $display("FAIL rst_grant: got %b expected 0000", grant); else passed++;
    total++; if (mac_en !== 1'b0) $display("FAIL rst_mac_en: got %b expected 0", mac_en); else passed++;
    total++; if (mac_clr !== 1'b0) $display("FAIL rst_mac_clr: got %b expected 0", mac_clr); else passed++;
    total++; if (mac_last !== 1'b0) $display("FAIL rst_mac_last: got %b expected 0", mac_last); else passed++;
    total++; if (tap_idx !== 6'd0) $display("FAIL rst_tap_idx: got %0d expected 0", tap_idx); else passed++;
    total++; if (done !== 4'b0000) $display("FAIL rst_done: got %b expected 0000", done); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else passed++;
    total++; if (overrun !== 4'b0000) $display("FAIL rst_overrun: got %b expected 0000", overrun); else passed++;
    total++; if (state_dbg !== 2'd0) $display("FAIL rst_state: got %0d expected 0", state_dbg); else passed++;
  endtask

  // req=0001 at cycle t; c counts cycles after t.
  task automatic test_single();
    logic [3:0] e_grant, e_done;
    logic       e_en, e_clr, e_last, e_busy;
    apply_reset();
    pulse(4'b0001);
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) @(negedge clk);
      e_grant = (c <= 15) ? 4'b0001 : 4'b0000;
      e_en    = (c >= 2 && c <= 14);
      e_clr   = (c == 2);
      e_last  = (c == 14);
      e_done  = (c == 15) ? 4'b0001 : 4'b0000;
      e_busy  = (c >= 2 && c <= 15);
      total++; if (grant !== e_grant) $display("FAIL single_grant c=%0d: got %b expected %b", c, grant, e_grant); else passed++;
      total++; if (mac_en !== e_en) $display("FAIL single_mac_en c=%0d: got %b expected %b", c, mac_en, e_en); else passed++;
      total++; if (mac_clr !== e_clr) $display("FAIL single_mac_clr c=%0d: got %b expected %b", c, mac_clr, e_clr); else passed++;
      total++; if (mac_last !== e_last) $display("FAIL single_mac_last c=%0d: got %b expected %b", c, mac_last, e_last); else passed++;
      total++; if (done !== e_done) $display("FAIL single_done c=%0d: got %b expected %b", c, done, e_done); else passed++;
      total++; if (busy !== e_busy) $display("FAIL single_busy c=%0d: got %b expected %b", c, busy, e_busy); else passed++;
      if (e_en) begin
        total++; if (tap_idx !== 6'(c - 2)) $display("FAIL single_tap c=%0d: got %0d expected %0d", c, tap_idx, c - 2); else passed++;
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_q[$];
    int         gap_q[$];
    int         cyc;
    logic [3:0] seen, e_seen;
    int         e_gap;
    apply_reset();
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    gap_q = '{14, 21, 29, 34};
    pulse(4'b1111);
    while (exp_q.size() > 0) begin
      e_seen = exp_q.pop_front();
      e_gap  = gap_q.pop_front();
      wait_done(60, cyc, seen);
      total++; if (seen !== e_seen) $display("FAIL simul_order: got %b expected %b", seen, e_seen); else passed++;
      total++; if (cyc != e_gap) $display("FAIL simul_gap: got %0d expected %0d", cyc, e_gap); else passed++;
    end
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL simul_idle_busy: got %b expected 0", busy); else passed++;
    total++; if (grant !== 4'b0000) $display("FAIL simul_idle_grant: got %b expected 0000", grant); else passed++;
  endtask

  task automatic test_round_robin();
    int         cyc;
    logic [3:0] seen;
    apply_reset();
    pulse(4'b0010);
    repeat (2) @(negedge clk);
    pulse(4'b0001);
    @(negedge clk);
    pulse(4'b0100);
    total++; if (overrun !== 4'b0000) $display("FAIL rr_overrun: got %b expected 0000", overrun); else passed++;
    wait_done(40, cyc, seen);
    total++; if (seen !== 4'b0010) $display("FAIL rr_first: got %b expected 0010", seen); else passed++;
    wait_done(40, cyc, seen);
    total++; if (seen !== 4'b0100) $display("FAIL rr_second: got %b expected 0100", seen); else passed++;
    total++; if (cyc != 29) $display("FAIL rr_second_gap: got %0d expected 29", cyc); else passed++;
    wait_done(40, cyc, seen);
    total++; if (seen !== 4'b0001) $display("FAIL rr_third: got %b expected 0001", seen); else passed++;
    total++; if (cyc != 15) $display("FAIL rr_third_gap: got %0d expected 15", cyc); else passed++;
  endtask

  task automatic test_back_to_back();
    int         cyc;
    logic [3:0] seen;
    apply_reset();
    // Re-request in the very cycle stage 0 is granted: the set must survive.
    pulse(4'b0001);
    total++; if (grant !== 4'b0001) $display("FAIL b2b_grant: got %b expected 0001", grant); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL b2b_arb_busy: got %b expected 0", busy); else passed++;
    pulse(4'b0001);
    total++; if (mac_clr !== 1'b1) $display("FAIL b2b_clr: got %b expected 1", mac_clr); else passed++;
    wait_done(40, cyc, seen);
    total++; if (seen !== 4'b0001) $display("FAIL b2b_done1: got %b expected 0001", seen); else passed++;
    total++; if (cyc != 13) $display("FAIL b2b_done1_gap: got %0d expected 13", cyc); else passed++;
    wait_done(40, cyc, seen);
    total++; if (seen !== 4'b0001) $display("FAIL b2b_done2: got %b expected 0001", seen); else passed++;
    total++; if (cyc != 15) $display("FAIL b2b_done2_gap: got %0d expected 15", cyc); else passed++;
    total++; if (overrun !== 4'b0000) $display("FAIL b2b_overrun1: got %b expected 0000", overrun); else passed++;
    @(negedge clk);
    // New sample from the owner while it is running: pending only.
    pulse(4'b0001);
    repeat (3) @(negedge clk);
    pulse(4'b0001);
    total++; if (overrun !== 4'b0000) $display("FAIL b2b_overrun2: got %b expected 0000", overrun); else passed++;
    wait_done(40, cyc, seen);
    total++; if (seen !== 4'b0001) $display("FAIL b2b_done3: got %b expected 0001", seen); else passed++;
    wait_done(40, cyc, seen);
    total++; if (seen !== 4'b0001) $display("FAIL b2b_done4: got %b expected 0001", seen); else passed++;
    total++; if (cyc != 15) $display("FAIL b2b_done4_gap: got %0d expected 15", cyc); else passed++;
  endtask

  task automatic test_overrun();
    int         cyc;
    logic [3:0] seen;
    apply_reset();
    pulse(4'b0010);
    repeat (2) @(negedge clk);
    pulse(4'b0100);
    @(negedge clk);
    pulse(4'b0100);
    total++; if (overrun !== OVR_EXP) $display("FAIL ovr_set: got %b expected %b", overrun, OVR_EXP); else passed++;
    wait_done(40, cyc, seen);
    total++; if (seen !== 4'b0010) $display("FAIL ovr_done1: got %b expected 0010", seen); else passed++;
    wait_done(40, cyc, seen);
    total++; if (seen !== 4'b0100) $display("FAIL ovr_done2: got %b expected 0100", seen); else passed++;
    total++; if (overrun !== OVR_EXP) $display("FAIL ovr_sticky: got %b expected %b", overrun, OVR_EXP); else passed++;
    wait_done(60, cyc, seen);
    total++; if (seen !== 4'b0000) $display("FAIL ovr_single_service: got %b expected 0000", seen); else passed++;
    total++; if (overrun !== OVR_EXP) $display("FAIL ovr_sticky2: got %b expected %b", overrun, OVR_EXP); else passed++;
  endtask

  task automatic test_reset_mid_run();
    int         cyc;
    logic [3:0] seen;
    apply_reset();
    pulse(4'b1000);
    repeat (2) @(negedge clk);
    pulse(4'b0001);
    repeat (5) @(negedge clk);
    total++; if (tap_idx !== 6'd7) $display("FAIL mid_tap7: got %0d expected 7", tap_idx); else passed++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++; if (grant !== 4'b0000) $display("FAIL mid_grant: got %b expected 0000", grant); else passed++;
    total++; if (mac_en !== 1'b0) $display("FAIL mid_mac_en: got %b expected 0", mac_en); else passed++;
    total++; if (tap_idx !== 6'd0) $display("FAIL mid_tap: got %0d expected 0", tap_idx); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b expected 0", busy); else passed++;
    total++; if (done !== 4'b0000) $display("FAIL mid_done: got %b expected 0000", done); else passed++;
    wait_done(60, cyc, seen);
    total++; if (seen !== 4'b0000) $display("FAIL mid_no_done: got %b expected 0000", seen); else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_simultaneous();
    test_round_robin();
    test_back_to_back();
    test_overrun();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
